// File: rtl/slice_cmp_seq.sv
// slice_cmp_seq: serial unsigned magnitude compare, one 2-bit slice per clock.
// Ports: clk, rst_n, start, a, b -> busy, done, lt, eq, gt, nslices.
module slice_cmp_seq #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic                       busy,
    output logic                       done,
    output logic                       lt,
    output logic                       eq,
    output logic                       gt,
    output logic [$clog2(WIDTH/2):0]   nslices
);

    localparam int NSL = WIDTH / 2;
    localparam int NW  = $clog2(NSL) + 1;
    localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [IW-1:0]  idx;
    logic [1:0]     sa;
    logic [1:0]     sb;
    logic           s_lt;
    logic           s_eq;
    logic           s_gt;

    // Current slice, selected by shifting the captured operands down.
    assign sa = 2'(a_r >> {idx, 1'b0});
    assign sb = 2'(b_r >> {idx, 1'b0});

    always_comb begin
        s_lt = 1'b0;
        s_eq = 1'b0;
        s_gt = 1'b0;
        unique case (1'b1)
            (sa < sb): s_lt = 1'b1;
            (sa > sb): s_gt = 1'b1;
            default:   s_eq = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = CMP;
                end
            end
            CMP: begin
                // Stop at the first differing slice or after the LSB slice.
                if (!s_eq || idx == '0) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state == CMP);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            idx     <= '0;
            lt      <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
            nslices <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        idx     <= IW'(NSL - 1);
                        lt      <= 1'b0;
                        eq      <= 1'b0;
                        gt      <= 1'b0;
                        nslices <= '0;
                    end
                end
                CMP: begin
                    nslices <= nslices + NW'(1);
                    if (!s_eq) begin
                        lt <= s_lt;
                        gt <= s_gt;
                        eq <= 1'b0;
                    end else if (idx == '0) begin
                        eq <= 1'b1;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slice_cmp_seq.sv
// tb_slice_cmp_seq: directed and random checks of slice_cmp_seq (WIDTH=8)
// against a slice-level reference model computed with plain arithmetic.
module tb_slice_cmp_seq;

    localparam int WIDTH = 8;
    localparam int NSL   = WIDTH / 2;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             lt;
    logic             eq;
    logic             gt;
    logic [2:0]       nslices;

    int tests;
    int fails;

    slice_cmp_seq #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .lt      (lt),
        .eq      (eq),
        .gt      (gt),
        .nslices (nslices)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Result is {lt,eq,gt}; k is how many MSB-first slices are examined.
    task automatic model(input logic [7:0] ma, input logic [7:0] mb,
                         output logic [2:0] res, output int k);
        int ia;
        int ib;
        ia  = int'(ma);
        ib  = int'(mb);
        res = {ia < ib, ia == ib, ia > ib};
        k   = NSL;
        for (int i = NSL - 1; i >= 0; i--) begin
            if (((ia >> (2 * i)) & 3) != ((ib >> (2 * i)) & 3)) begin
                k = NSL - i;
                break;
            end
        end
    endtask

    task automatic do_cmp(input logic [7:0] ta, input logic [7:0] tb_v,
                          input bit scr);
        logic [2:0] e_res;
        int         k;
        int         edges;
        bit         got;
        model(ta, tb_v, e_res, k);
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_capture", busy, 1);
        chk("no_done_in_cmp", done, 0);
        got = 1'b0;
        for (int n = 0; n < NSL + 2 && !got; n++) begin
            if (scr) begin
                a     = 8'($urandom);
                b     = 8'($urandom);
                start = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
            start = 1'b0;
            if (done) got = 1'b1;
        end
        chk("done_seen", got, 1);
        chk("latency_edges", edges, k + 1);
        chk("result_lt_eq_gt", {lt, eq, gt}, e_res);
        chk("nslices", nslices, k);
        chk("busy_in_done", busy, 0);
        @(negedge clk);
        chk("single_done_pulse", done, 0);
        chk("busy_idle", busy, 0);
        chk("hold_result", {lt, eq, gt}, e_res);
        chk("hold_nslices", nslices, k);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        chk("rst_outputs", {busy, done, lt, eq, gt}, 0);
        chk("rst_nslices", nslices, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        do_cmp(8'h40, 8'h3F, 1'b0);
        chk("dir_40_3f_gt", {lt, eq, gt}, 3'b001);
        chk("dir_40_3f_k", nslices, 1);
        do_cmp(8'hA5, 8'hA5, 1'b0);
        chk("dir_a5_eq", {lt, eq, gt}, 3'b010);
        chk("dir_a5_k", nslices, 4);
        do_cmp(8'h12, 8'h13, 1'b0);
        chk("dir_12_13_lt", {lt, eq, gt}, 3'b100);
        do_cmp(8'h1C, 8'h2C, 1'b0);
        chk("dir_1c_2c_k", nslices, 2);
        do_cmp(8'h00, 8'hFF, 1'b1);
        chk("dir_scramble_lt", {lt, eq, gt}, 3'b100);
        chk("dir_scramble_k", nslices, 1);

        // Reset in the third CMP cycle aborts without a done pulse.
        @(negedge clk);
        a     = 8'h55;
        b     = 8'h55;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("busy_before_abort", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {busy, done, lt, eq, gt}, 0);
        chk("abort_nslices", nslices, 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        rst_n = 1'b1;
        do_cmp(8'h03, 8'h01, 1'b0);
        chk("post_rst_gt", {lt, eq, gt}, 3'b001);
        chk("post_rst_k", nslices, 4);

        // Continuous start: one compare every three cycles.
        @(negedge clk);
        a     = 8'hC0;
        b     = 8'h80;
        start = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            @(negedge clk);
            chk("b2b_done", done, (n % 3) == 2);
            chk("b2b_busy", busy, (n % 3) == 1);
            if ((n % 3) == 2) chk("b2b_gt", {lt, eq, gt}, 3'b001);
        end
        start = 1'b0;
        @(negedge clk);

        // Random compares with biased operands to reach every slice depth.
        for (int t = 0; t < 40; t++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = 8'($urandom);
                1:       rb = ra ^ (8'd1 << $urandom_range(0, 7));
                default: rb = ra;
            endcase
            do_cmp(ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/slice_cmp_seq.md
SLICE_CMP_SEQ -- requirements
Module: slice_cmp_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; SHALL be even and >= 2.
REQ-002 Derived constant NSL = WIDTH/2 SHALL be the number of 2-bit slices per operand.
REQ-003 Port: clk  in  1  sole clock, all state on rising edge.
REQ-004 Port: rst_n  in  1  asynchronous active-low reset.
REQ-005 Port: start  in  1  request a compare of a and b.
REQ-006 Port: a  in  WIDTH  operand A, unsigned.
REQ-007 Port: b  in  WIDTH  operand B, unsigned.
REQ-008 Port: busy  out  1  high while a compare is in progress (state CMP).
REQ-009 Port: done  out  1  one-cycle pulse when the result is valid.
REQ-010 Port: lt  out  1  result A < B.
REQ-011 Port: eq  out  1  result A == B.
REQ-012 Port: gt  out  1  result A > B.
REQ-013 Port: nslices  out  clog2(NSL)+1  number of slices examined by the last compare.

Function
REQ-014 The block SHALL compare a and b serially, one 2-bit slice per clock, MSB slice first, using an internal combinational 2-bit compare (lt/eq/gt, one-hot).
REQ-015 FSM states SHALL be IDLE, CMP and DONE.
REQ-016 IDLE: start=1 on an edge -> capture a and b into internal registers, set slice index to NSL-1, clear lt/eq/gt and nslices to 0, go to CMP.
REQ-017 IDLE: start=0 -> stay in IDLE; all outputs hold.
REQ-018 CMP, slice index i: registered slices A[2i+1:2i] and B[2i+1:2i] SHALL be compared, and nslices SHALL increment by 1 on every CMP edge.
REQ-019 CMP, slice unequal -> set lt or gt per the slice result, eq=0, go to DONE (early termination).
REQ-020 CMP, slice equal and i==0 -> set eq=1, go to DONE.
REQ-021 CMP, slice equal and i>0 -> decrement i, stay in CMP.
REQ-022 DONE SHALL last exactly one cycle and then go to IDLE unconditionally.
REQ-023 done SHALL equal (state==DONE), and busy SHALL equal (state==CMP).
REQ-024 Latency: with k slices examined (1 <= k <= NSL), done SHALL be high in the cycle following edge k+1, counting the capture edge as edge 1.
REQ-025 lt, eq, gt and nslices SHALL hold their values after DONE until the next accepted start.
REQ-026 lt, eq and gt SHALL be exactly one-hot whenever done=1.
REQ-027 start SHALL be ignored in CMP and DONE; changes to a and b after capture SHALL NOT affect the result.
REQ-028 start asserted continuously SHALL launch a new compare on the first IDLE edge after DONE, giving back-to-back compares with one IDLE cycle between them.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE and busy=0, done=0, lt=0, eq=0, gt=0, nslices=0, with operand registers and slice index cleared.
REQ-030 Reset asserted during CMP or DONE SHALL abort the compare with no done pulse; after rst_n is released the block SHALL accept start on the first edge.

Verification (WIDTH=8)
REQ-031 a=8'h40, b=8'h3F, start pulse -> done high after edge 2, gt=1, lt=0, eq=0, nslices=1.
REQ-032 a=8'hA5, b=8'hA5 -> done high after edge 5, eq=1, nslices=4.
REQ-033 a=8'h12, b=8'h13 -> done after edge 5, lt=1, nslices=4; a=8'h1C, b=8'h2C -> lt=1, nslices=2.
REQ-034 Start a=8'h00, b=8'hFF, then change a to 8'hFF and pulse start during CMP -> change ignored, lt=1, nslices=1, only one done pulse.
REQ-035 Start a=8'h55, b=8'h55, assert rst_n=0 at the third CMP cycle -> all outputs 0 immediately, no done; after release, start a=8'h03, b=8'h01 -> gt=1, nslices=4.
REQ-036 Hold start=1 with a=8'hC0, b=8'h80 -> done pulses every 3 cycles, gt=1 each time, busy low in the IDLE and DONE cycles.
